// File: rtl/sevseg_scan_controller.sv
// Four-digit common-anode seven-segment scan controller with dead-time blanking and a frame-synchronised shadow register.
// Optional: define SEVSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module sevseg_scan_controller #(
    parameter int CLOCK_DIV    = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        cmosClock,
    input  logic        reset,
    input  logic [15:0] dataIn,
    input  logic [3:0]  dpIn,
    input  logic        dataValid,
    output logic        dataReady,
    output logic        frameStart,
    output logic [3:0]  sevenSegmentEnable,
    output logic [7:0]  sevenSegmentData
);

    localparam int PRESCALE_W = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

    typedef enum logic {
        SCAN_BLANK,
        SCAN_ON
    } scan_state_t;

    logic [PRESCALE_W-1:0] prescaler;
    logic [1:0]            digit_index;
    logic                  primed;
    scan_state_t           state;
    scan_state_t           state_next;

    logic [15:0] display_data;
    logic [3:0]  display_dp;
    logic [15:0] pending_data;
    logic [3:0]  pending_dp;
    logic        pending;
    logic        pending_next;

    logic        slot_end;
    logic        frame_end;
    logic        accept;
    logic [3:0]  nibble;
    logic [6:0]  segments;
    logic        blank_digit;
    logic [3:0]  enable_next;
    logic [7:0]  segment_next;

    assign slot_end  = (prescaler == PRESCALE_W'(CLOCK_DIV - 1));
    // The first slot after reset acts as a priming slot, so its boundary already starts a frame on digit 0.
    assign frame_end = slot_end && ((digit_index == 2'd3) || !primed);
    assign accept    = dataValid && dataReady;
    assign pending_next = accept || (pending && !frame_end);

    always_ff @(posedge cmosClock) begin
        if (reset) begin
            prescaler   <= '0;
            digit_index <= 2'd0;
            primed      <= 1'b0;
        end else if (slot_end) begin
            prescaler   <= '0;
            primed      <= 1'b1;
            digit_index <= primed ? digit_index + 2'd1 : 2'd0;
        end else begin
            prescaler   <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge cmosClock) begin
        if (reset) begin
            state <= SCAN_BLANK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (slot_end) begin
            state_next = (BLANK_CYCLES == 0) ? SCAN_ON : SCAN_BLANK;
        end else if ((state == SCAN_BLANK) && (prescaler == PRESCALE_W'(BLANK_CYCLES - 1))) begin
            state_next = SCAN_ON;
        end
    end

    // Shadow register only reaches the display at a frame boundary, which keeps frames tear-free.
    always_ff @(posedge cmosClock) begin
        if (reset) begin
            pending      <= 1'b0;
            pending_data <= 16'h0000;
            pending_dp   <= 4'h0;
            display_data <= 16'h0000;
            display_dp   <= 4'h0;
            dataReady    <= 1'b0;
            frameStart   <= 1'b0;
        end else begin
            frameStart <= frame_end;
            if (frame_end && pending) begin
                display_data <= pending_data;
                display_dp   <= pending_dp;
            end
            if (accept) begin
                pending_data <= dataIn;
                pending_dp   <= dpIn;
            end
            pending   <= pending_next;
            dataReady <= !pending_next;
        end
    end

    assign nibble = display_data[{digit_index, 2'b00} +: 4];

    always_comb begin
        case (nibble)
            4'h0:    segments = 7'h40;
            4'h1:    segments = 7'h79;
            4'h2:    segments = 7'h24;
            4'h3:    segments = 7'h30;
            4'h4:    segments = 7'h19;
            4'h5:    segments = 7'h12;
            4'h6:    segments = 7'h02;
            4'h7:    segments = 7'h78;
            4'h8:    segments = 7'h00;
            4'h9:    segments = 7'h10;
            4'hA:    segments = 7'h08;
            4'hB:    segments = 7'h03;
            4'hC:    segments = 7'h46;
            4'hD:    segments = 7'h21;
            4'hE:    segments = 7'h06;
            default: segments = 7'h0E;
        endcase
    end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    assign blank_digit = (digit_index != 2'd0) && ((display_data >> {digit_index, 2'b00}) == 16'h0000);
`else
    assign blank_digit = 1'b0;
`endif

    always_comb begin
        enable_next  = 4'b1111;
        segment_next = 8'hFF;
        if (state == SCAN_ON) begin
            enable_next  = ~(4'b0001 << digit_index);
            segment_next = {~display_dp[digit_index], blank_digit ? 7'h7F : segments};
        end
    end

    always_ff @(posedge cmosClock) begin
        if (reset) begin
            sevenSegmentEnable <= 4'b1111;
            sevenSegmentData   <= 8'hFF;
        end else begin
            sevenSegmentEnable <= enable_next;
            sevenSegmentData   <= segment_next;
        end
    end

endmodule

// File: tb/tb_sevseg_scan_controller.sv
// Randomised and directed bench for sevseg_scan_controller against a cycle-count based display model.
// Expectations follow SEVSEG_LEADING_ZERO_BLANK_EN when the macro is defined for the build.
module tb_sevseg_scan_controller;

    localparam int CLOCK_DIV    = 8;
    localparam int BLANK_CYCLES = 2;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        cmosClock = 1'b0;
    logic        reset     = 1'b1;
    logic [15:0] dataIn    = 16'h0000;
    logic [3:0]  dpIn      = 4'h0;
    logic        dataValid = 1'b0;
    logic        dataReady;
    logic        frameStart;
    logic [3:0]  sevenSegmentEnable;
    logic [7:0]  sevenSegmentData;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic        m_pend     = 1'b0;
    logic        m_ready    = 1'b0;
    logic [19:0] m_pend_val = 20'h0;
    logic [19:0] m_disp     = 20'h0;

    sevseg_scan_controller #(
        .CLOCK_DIV   (CLOCK_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .cmosClock         (cmosClock),
        .reset             (reset),
        .dataIn            (dataIn),
        .dpIn              (dpIn),
        .dataValid         (dataValid),
        .dataReady         (dataReady),
        .frameStart        (frameStart),
        .sevenSegmentEnable(sevenSegmentEnable),
        .sevenSegmentData  (sevenSegmentData)
    );

    always #5 cmosClock = ~cmosClock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, observed, expected);
        end
    endtask

    // Digit shown in the cycle after k edges since reset release; slot 0 is the priming slot.
    function automatic int slot_digit(input int k);
        int n;
        n = k / CLOCK_DIV;
        return (n == 0) ? 0 : (n - 1) % 4;
    endfunction

    function automatic logic is_frame_edge(input int c);
        return (c >= CLOCK_DIV) && (c % CLOCK_DIV == 0) && (slot_digit(c) == 0);
    endfunction

    function automatic logic [7:0] expected_segments(input logic [19:0] disp, input int digit);
        logic [3:0] nib;
        logic [6:0] seg;
        logic       dp;
        nib = disp[digit*4 +: 4];
        dp  = disp[16 + digit];
        seg = SEG_LUT[nib];
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        if ((digit > 0) && ((disp[15:0] >> (digit * 4)) == 16'h0000)) seg = 7'h7F;
`endif
        return {~dp, seg};
    endfunction

    task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic [3:0] dp, input logic rst);
        int         p;
        int         d;
        logic       frame;
        logic       accept;
        logic [3:0] exp_en;
        logic [7:0] exp_data;
        dataValid = valid;
        dataIn    = data;
        dpIn      = dp;
        reset     = rst;
        @(posedge cmosClock);
        if (rst) begin
            cyc        = 0;
            m_pend     = 1'b0;
            m_ready    = 1'b0;
            m_pend_val = 20'h0;
            m_disp     = 20'h0;
            frame      = 1'b0;
            exp_en     = 4'b1111;
            exp_data   = 8'hFF;
        end else begin
            cyc++;
            p = (cyc - 1) % CLOCK_DIV;
            d = slot_digit(cyc - 1);
            if (p < BLANK_CYCLES) begin
                exp_en   = 4'b1111;
                exp_data = 8'hFF;
            end else begin
                exp_en   = ~(4'b0001 << d);
                exp_data = expected_segments(m_disp, d);
            end
            frame  = is_frame_edge(cyc);
            accept = valid && m_ready;
            if (frame && m_pend) begin
                m_disp = m_pend_val;
                m_pend = 1'b0;
            end
            if (accept) begin
                m_pend_val = {dp, data};
                m_pend     = 1'b1;
            end
            m_ready = !m_pend;
        end
        #1;
        checkOutput("enable", {12'h0, sevenSegmentEnable}, {12'h0, exp_en});
        checkOutput("segments", {8'h0, sevenSegmentData}, {8'h0, exp_data});
        checkOutput("ready", {15'h0, dataReady}, {15'h0, m_ready});
        checkOutput("frame_start", {15'h0, frameStart}, {15'h0, frame});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'($urandom), 4'($urandom), 1'b0);
    endtask

    task automatic loadValue(input logic [15:0] data, input logic [3:0] dp);
        for (int i = 0; i < 100 && !m_ready; i++) idle(1);
        checkOutput("wait_ready", {15'h0, m_ready}, 16'd1);
        applyStimulus(1'b1, data, dp, 1'b0);
    endtask

    initial begin
        int   first_fs;
        logic ok;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 4'h0, 1'b1);
        first_fs = 0;
        for (int i = 1; i <= 40 && first_fs == 0; i++) begin
            idle(1);
            if (frameStart) first_fs = i;
        end
        checkOutput("first_frame_start_delay", 16'(first_fs), 16'(CLOCK_DIV));

        loadValue(16'h1A3F, 4'b0100);
        idle(CLOCK_DIV * 4 * 3);

        loadValue(16'h1111, 4'b0000);
        idle(CLOCK_DIV + 3);
        for (int i = 0; i < CLOCK_DIV * 4 * 3; i++) applyStimulus(1'b1, 16'h2222, 4'b0011, 1'b0);
        checkOutput("hold_accepted", m_disp[15:0], 16'h2222);

        idle(CLOCK_DIV * 4 + 1);
        for (int i = 0; i < 200 && !(is_frame_edge(cyc + 1) && !m_pend); i++) idle(1);
        ok = is_frame_edge(cyc + 1) && !m_pend;
        checkOutput("wait_wrap_edge", {15'h0, ok}, 16'd1);
        applyStimulus(1'b1, 16'hBEEF, 4'b1001, 1'b0);
        checkOutput("beef_not_yet_shown", {15'h0, m_disp[15:0] == 16'hBEEF}, 16'd0);
        idle(CLOCK_DIV * 4 * 2 + 2);
        checkOutput("beef_shown", m_disp[15:0], 16'hBEEF);

        for (int i = 0; i < 200 && !is_frame_edge(cyc); i++) idle(1);
        loadValue(16'hCAFE, 4'b0110);
        for (int i = 0; i < 200 && !(slot_digit(cyc) == 2 && (cyc % CLOCK_DIV) >= BLANK_CYCLES + 1); i++) idle(1);
        checkOutput("pending_before_reset", {15'h0, m_pend}, 16'd1);
        applyStimulus(1'b0, 16'h0, 4'h0, 1'b1);
        idle(CLOCK_DIV * 4 * 2 + 4);
        checkOutput("pending_discarded", {12'h0, m_disp[19:16], 16'h0}, 16'h0);

        loadValue(16'h0050, 4'b0000);
        idle(CLOCK_DIV * 4 * 3);

        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                applyStimulus(1'b0, 16'h0, 4'h0, 1'b1);
            end else begin
                applyStimulus($urandom_range(0, 2) == 0, 16'($urandom), 4'($urandom), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
